// File: rtl/alu_issue_stage_if.sv
// ID-side request and EX-side ALU bundle of the ALU issue stage.
// master is the issue stage, slave is the surrounding ID/EX environment.
interface alu_issue_stage_if;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_rs_val;
    logic [31:0] id_rt_val;
    logic        ex_valid;
    logic        ex_ready;
    logic [3:0]  ex_alu_ctr;
    logic [31:0] ex_in1;
    logic [31:0] ex_in2;
    logic [4:0]  ex_wdst;
    logic        ex_wen;
    logic        ex_illegal;

    modport master (
        input  id_valid, id_instr, id_rs_val, id_rt_val, ex_ready,
        output id_ready, ex_valid, ex_alu_ctr, ex_in1, ex_in2,
        output ex_wdst, ex_wen, ex_illegal
    );

    modport slave (
        output id_valid, id_instr, id_rs_val, id_rt_val, ex_ready,
        input  id_ready, ex_valid, ex_alu_ctr, ex_in1, ex_in2,
        input  ex_wdst, ex_wen, ex_illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// MIPS ID-stage ALU decode feeding the ID/EX register over valid/ready,
// with flush and a saturating illegal-instruction counter.
module alu_issue_stage #(
    parameter int ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_i,
    alu_issue_stage_if.master    bus,
    output logic [ILL_CNT_W-1:0] ill_cnt_o
);

    typedef struct packed {
        logic [3:0]  ctr;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [4:0]  wdst;
        logic        wen;
        logic        ill;
    } ex_pay_t;

    localparam logic [3:0] C_ADD  = 4'b0001;
    localparam logic [3:0] C_SUB  = 4'b0010;
    localparam logic [3:0] C_AND  = 4'b0100;
    localparam logic [3:0] C_OR   = 4'b0101;
    localparam logic [3:0] C_XOR  = 4'b0110;
    localparam logic [3:0] C_NOR  = 4'b0111;
    localparam logic [3:0] C_SLL  = 4'b1000;
    localparam logic [3:0] C_LUI  = 4'b1001;
    localparam logic [3:0] C_SRL  = 4'b1010;
    localparam logic [3:0] C_SRA  = 4'b1011;
    localparam logic [3:0] C_SLT  = 4'b1100;
    localparam logic [3:0] C_SLTU = 4'b1101;
    localparam logic [3:0] C_JR   = 4'b1110;

    localparam ex_pay_t BUBBLE = '{
        ctr:  C_ADD,
        in1:  32'd0,
        in2:  32'd0,
        wdst: 5'd0,
        wen:  1'b0,
        ill:  1'b0
    };

    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
    logic [15:0] imm;
    logic [31:0] sext;
    logic [31:0] zext;

    assign op   = bus.id_instr[31:26];
    assign rs   = bus.id_instr[25:21];
    assign rt   = bus.id_instr[20:16];
    assign rd   = bus.id_instr[15:11];
    assign sh   = bus.id_instr[10:6];
    assign fn   = bus.id_instr[5:0];
    assign imm  = bus.id_instr[15:0];
    assign sext = {{16{imm[15]}}, imm};
    assign zext = {16'd0, imm};

    ex_pay_t dec;
    logic    dec_ok;

    always_comb begin
        dec      = BUBBLE;
        dec_ok   = 1'b1;
        dec.in1  = bus.id_rs_val;
        dec.in2  = bus.id_rt_val;
        dec.wdst = rt;
        dec.wen  = 1'b1;
        unique case (op)
            6'h00: begin
                dec.wdst = rd;
                unique case (fn)
                    6'h20, 6'h21: dec.ctr = C_ADD;
                    6'h22, 6'h23: dec.ctr = C_SUB;
                    6'h24: dec.ctr = C_AND;
                    6'h25: dec.ctr = C_OR;
                    6'h26: dec.ctr = C_XOR;
                    6'h27: dec.ctr = C_NOR;
                    6'h2A: dec.ctr = C_SLT;
                    6'h2B: dec.ctr = C_SLTU;
                    6'h00: begin
                        dec.ctr = C_SLL;
                        dec.in1 = {27'd0, sh};
                    end
                    6'h02: begin
                        dec.ctr = C_SRL;
                        dec.in1 = {27'd0, sh};
                    end
                    6'h03: begin
                        dec.ctr = C_SRA;
                        dec.in1 = {27'd0, sh};
                    end
                    6'h04: begin
                        dec.ctr = C_SLL;
                        dec.in1 = {27'd0, bus.id_rs_val[4:0]};
                    end
                    6'h06: begin
                        dec.ctr = C_SRL;
                        dec.in1 = {27'd0, bus.id_rs_val[4:0]};
                    end
                    6'h07: begin
                        dec.ctr = C_SRA;
                        dec.in1 = {27'd0, bus.id_rs_val[4:0]};
                    end
                    6'h08: begin
                        dec.ctr = C_JR;
                        dec.in2 = 32'd0;
                        dec.wen = 1'b0;
                    end
                    default: dec_ok = 1'b0;
                endcase
            end
            6'h08, 6'h09: begin
                dec.ctr = C_ADD;
                dec.in2 = sext;
            end
            6'h0A: begin
                dec.ctr = C_SLT;
                dec.in2 = sext;
            end
            6'h0B: begin
                dec.ctr = C_SLTU;
                dec.in2 = sext;
            end
            6'h0C: begin
                dec.ctr = C_AND;
                dec.in2 = zext;
            end
            6'h0D: begin
                dec.ctr = C_OR;
                dec.in2 = zext;
            end
            6'h0E: begin
                dec.ctr = C_XOR;
                dec.in2 = zext;
            end
            6'h0F: begin
                dec.ctr = C_LUI;
                dec.in1 = 32'd0;
                dec.in2 = zext;
            end
            6'h23: begin
                dec.ctr = C_ADD;
                dec.in2 = sext;
            end
            6'h2B: begin
                dec.ctr = C_ADD;
                dec.in2 = sext;
                dec.wen = 1'b0;
            end
            6'h04, 6'h05: begin
                dec.ctr = C_SUB;
                dec.wen = 1'b0;
            end
            default: dec_ok = 1'b0;
        endcase
        // $0 is hardwired, so a write to it is never a real writeback
        if (dec.wdst == 5'd0) dec.wen = 1'b0;
        if (!dec_ok) begin
            dec     = BUBBLE;
            dec.ill = 1'b1;
        end
    end

    ex_pay_t               pay_q, pay_d;
    logic                  valid_q, valid_d;
    logic [ILL_CNT_W-1:0]  cnt_q, cnt_d;
    logic                  ready;
    logic                  load;

    assign ready = !valid_q || bus.ex_ready;
    assign load  = bus.id_valid && ready && !flush_i;

    always_comb begin
        valid_d = valid_q;
        pay_d   = pay_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            valid_d = 1'b0;
            pay_d   = BUBBLE;
        end else if (load) begin
            valid_d = 1'b1;
            pay_d   = dec;
            if (dec.ill && (cnt_q != {ILL_CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
        end else if (valid_q && bus.ex_ready) begin
            valid_d = 1'b0;
            pay_d   = BUBBLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pay_q   <= BUBBLE;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pay_q   <= pay_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.id_ready   = ready;
    assign bus.ex_valid   = valid_q;
    assign bus.ex_alu_ctr = pay_q.ctr;
    assign bus.ex_in1     = pay_q.in1;
    assign bus.ex_in2     = pay_q.in2;
    assign bus.ex_wdst    = pay_q.wdst;
    assign bus.ex_wen     = pay_q.wen;
    assign bus.ex_illegal = pay_q.ill;
    assign ill_cnt_o      = cnt_q;

endmodule
